// File: rtl/serial_frame_deserializer.sv
// Serial-to-parallel frame receiver: start(1), data MSB first, optional even parity, stop(0).
// Good words are held on data_out under a valid/ready handshake; errors are one-cycle pulses.
module serial_frame_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  serial_in,
    input  logic                  data_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  frame_error,
    output logic                  overrun
);

    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] shift;
    logic                  parity_bad;
    logic                  frame_good;
    logic                  can_load;
    logic                  consume;

    // A frame is good only when the stop bit is low and the parity check passed.
    assign frame_good = (state == STOP) && !serial_in && !parity_bad;
    assign consume    = data_valid && data_ready;
    assign can_load   = !data_valid || data_ready;

    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= IDLE;
            count        <= '0;
            shift        <= '0;
            parity_bad   <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;

            case (state)
                IDLE: begin
                    if (serial_in) begin
                        state      <= DATA;
                        count      <= '0;
                        parity_bad <= 1'b0;
                    end
                end
                DATA: begin
                    shift <= {shift[DATA_WIDTH-2:0], serial_in};
                    if (count == CW'(DATA_WIDTH - 1)) begin
                        count <= '0;
                        state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                PARITY: begin
                    parity_bad <= (^shift) ^ serial_in;
                    state      <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                    if (serial_in) begin
                        frame_error <= 1'b1;
                    end else if (parity_bad) begin
                        parity_error <= 1'b1;
                    end else if (!can_load) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A load in the same cycle as a consume keeps the word valid.
            if (consume) begin
                data_valid <= 1'b0;
            end
            if (frame_good && can_load) begin
                data_out   <= shift;
                data_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer: a frame-level model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_serial_frame_deserializer;

    localparam int DW = 8;
    localparam int PE = 1;

    logic          clk = 1'b0;
    logic          clear;
    logic          serial_in;
    logic          data_ready;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_error;
    logic          frame_error;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    logic base_ready;

    serial_frame_deserializer #(.DATA_WIDTH(DW), .PARITY_EN(PE)) dut (
        .clk(clk),
        .clear(clear),
        .serial_in(serial_in),
        .data_ready(data_ready),
        .data_out(data_out),
        .data_valid(data_valid),
        .parity_error(parity_error),
        .frame_error(frame_error),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Frame-level model: collect bits after a start bit, then judge the whole frame at once.
    bit            m_live = 1'b0;
    bit            m_in_frame;
    logic          m_bits[$];
    logic [DW-1:0] m_out;
    logic          m_valid, m_pe, m_fe, m_ov;

    always @(posedge clk) begin
        int   word, ones;
        logic good, load, rdy, sin;
        m_pe = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (clear) begin
            m_live     = 1'b1;
            m_in_frame = 1'b0;
            m_bits.delete();
            m_out      = '0;
            m_valid    = 1'b0;
        end else if (m_live) begin
            rdy  = data_ready;
            sin  = serial_in;
            good = 1'b0;
            word = 0;
            if (!m_in_frame) begin
                if (sin) begin
                    m_in_frame = 1'b1;
                    m_bits.delete();
                end
            end else begin
                m_bits.push_back(sin);
                if (m_bits.size() == DW + PE + 1) begin
                    ones = 0;
                    for (int i = 0; i < DW; i++) begin
                        word = word * 2 + int'(m_bits[i]);
                        ones = ones + int'(m_bits[i]);
                    end
                    if (PE != 0) ones = ones + int'(m_bits[DW]);
                    if (m_bits[DW + PE]) m_fe = 1'b1;
                    else if (PE != 0 && (ones % 2) != 0) m_pe = 1'b1;
                    else good = 1'b1;
                    m_in_frame = 1'b0;
                end
            end
            load = good && (!m_valid || rdy);
            m_ov = good && !load;
            if (m_valid && rdy) m_valid = 1'b0;
            if (load) begin
                m_out   = word[DW-1:0];
                m_valid = 1'b1;
            end
        end
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check_output("model.data_out", 16'(data_out), 16'(m_out));
            check_output("model.data_valid", 16'(data_valid), 16'(m_valid));
            check_output("model.parity_error", 16'(parity_error), 16'(m_pe));
            check_output("model.frame_error", 16'(frame_error), 16'(m_fe));
            check_output("model.overrun", 16'(overrun), 16'(m_ov));
        end
    end

    task automatic apply_stimulus(input logic b);
        serial_in = b;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop, input logic rdy_stop);
        data_ready = base_ready;
        apply_stimulus(1'b1);
        for (int i = DW - 1; i >= 0; i--) apply_stimulus(d[i]);
        if (PE != 0) apply_stimulus(par);
        data_ready = rdy_stop;
        apply_stimulus(stop);
        data_ready = base_ready;
    endtask

    task automatic check_lit(input string name, input logic [DW-1:0] out, input logic v,
                             input logic pe, input logic fe, input logic ov);
        check_output({name, ".data_out"}, 16'(data_out), 16'(out));
        check_output({name, ".model_out"}, 16'(m_out), 16'(out));
        check_output({name, ".data_valid"}, 16'(data_valid), 16'(v));
        check_output({name, ".parity_error"}, 16'(parity_error), 16'(pe));
        check_output({name, ".frame_error"}, 16'(frame_error), 16'(fe));
        check_output({name, ".overrun"}, 16'(overrun), 16'(ov));
    endtask

    initial begin
        clear      = 1'b1;
        serial_in  = 1'b0;
        base_ready = 1'b1;
        data_ready = 1'b1;

        // Reset held while the line toggles, then idle low.
        apply_stimulus(1'b1);
        apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        check_lit("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0);
        check_lit("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check_lit("good_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0);
        check_lit("good_a5_drain", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        check_lit("parity_3c", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0);
        check_lit("parity_3c_end", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b0, 1'b1);
        check_lit("good_01", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);

        send_frame(8'h55, 1'b0, 1'b1, 1'b1);
        check_lit("frame_55", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0);
        check_lit("frame_55_end", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0);

        base_ready = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        check_lit("ovr_81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
        check_lit("ovr_7e", 8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
        data_ready = 1'b1;
        apply_stimulus(1'b0);
        check_lit("ovr_drain", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        data_ready = 1'b0;

        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        check_lit("hs_81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        check_lit("hs_7e", 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
        data_ready = 1'b1;
        apply_stimulus(1'b0);
        check_lit("hs_drain", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
        base_ready = 1'b1;

        // Partial frame of 0xF0 (start plus four ones) cut short by clear.
        apply_stimulus(1'b1);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1);
        clear = 1'b1;
        apply_stimulus(1'b0);
        clear = 1'b0;
        check_lit("mid_clear", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        check_lit("good_0f", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_deserializer.md
# serial_frame_deserializer

Serial-to-parallel frame receiver placed directly downstream of the 4-bit SISO shift register. It consumes the one-bit-per-clock stream on `serial_in`, frames it as start/data/parity/stop, and presents each good word on a parallel port with a valid/ready handshake. It flags parity, framing and overrun errors. The line idles low, matching the all-zero output of a cleared SISO stage.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 2–16.
- `PARITY_EN`, default 1: 1 = one even-parity bit follows the data; 0 = no parity bit.

- `clk`  in  1  rising-edge clock; one serial bit is sampled per edge.
- `clear`  in  1  synchronous, active-high reset.
- `serial_in`  in  1  serial line; idle = 0.
- `data_ready`  in  1  consumer accepts `data_out` when high while `data_valid` is high.
- `data_out`  out  DATA_WIDTH  last good received word.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `parity_error`  out  1  one-cycle pulse: frame discarded for bad parity.
- `frame_error`  out  1  one-cycle pulse: frame discarded for bad stop bit.
- `overrun`  out  1  one-cycle pulse: good frame dropped because the holding register was full.

## Operation
- **Frame format:**
  - start bit = 1;
  - DATA_WIDTH data bits, MSB first;
  - parity bit if PARITY_EN; even parity, so the data bits plus the parity bit contain an even number of ones;
  - stop bit = 0.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: `serial_in`=1 → DATA with the bit counter at 0. `serial_in`=0 → stay in IDLE.
  - DATA: shift `serial_in` into the LSB of the internal shift register and increment the counter. After bit DATA_WIDTH-1, go to PARITY if PARITY_EN, otherwise to STOP.
  - PARITY: compute `parity_bad` = XOR of the data bits and `serial_in`, then go to STOP.
  - STOP: always return to IDLE. Outcomes, in priority order:
    1. `serial_in`=1 → `frame_error` pulse, word discarded.
    2. Otherwise, if `parity_bad` → `parity_error` pulse, word discarded.
    3. Otherwise the frame is good.
  - A failing stop bit is never reinterpreted as a start bit.
- **Good frame delivery:**
  - If `data_valid`=0, or `data_ready`=1 in the same cycle: load `data_out` and set `data_valid`=1.
  - If `data_valid`=1 and `data_ready`=0: keep the old word and pulse `overrun`.
- **Handshake:**
  - A word is consumed on any edge where `data_valid` and `data_ready` are both 1.
  - Consumption with no simultaneous good-frame load clears `data_valid`.
  - Consumption with a simultaneous load keeps `data_valid`=1, with the new word on `data_out`.
  - `data_out` changes only on a load.
- **Back-to-back frames:** a start bit may arrive on the edge immediately after the stop bit. No idle gap is required.
- **Counter width:** the bit counter is clog2(DATA_WIDTH) bits.

## Timing
- **Reset:** `clear` is sampled on the rising edge and takes priority over everything. On the next edge:
  - state = IDLE, counter = 0, shift register = 0;
  - `data_out` = 0, `data_valid` = 0;
  - `parity_error`, `frame_error`, `overrun` = 0.
- **Reset mid-frame:** the partial frame is discarded and no flags are raised. The first edge after `clear` falls may already sample a start bit.
- **Frame length:** 2 + DATA_WIDTH + PARITY_EN edges.
- **Latency:** `data_out`, `data_valid` and the error pulses update on the edge that samples the stop bit. The stop bit therefore appears 1 cycle after it is driven.
- **Pulses:** every error pulse is exactly one cycle wide.
- **Error flag interaction:** at most one of `parity_error`, `frame_error`, `overrun` is high in any cycle. Error pulses do not affect `data_valid` or `data_out`.
- **Upstream alignment:** after the 4-stage SISO is cleared, its first 4 output bits are 0. This reads as idle, so no special alignment is needed.

## Test plan
- **Reset:** hold `clear`=1 for 3 cycles while `serial_in` toggles 1/0 → all outputs 0 and the FSM stays in IDLE. Release `clear` with `serial_in`=0 for 5 cycles → no outputs change.
- **Good frame (DATA_WIDTH=8, PARITY_EN=1, `data_ready`=1):** drive 1, 1,0,1,0,0,1,0,1, 0, 0 (start, 0xA5 MSB first, parity, stop) → `data_out`=0xA5 and `data_valid`=1 on the 11th edge. `data_valid` clears on the following edge. No error flags.
- **Parity error:** frame 0x3C with parity bit 1 → `parity_error` pulses for 1 cycle, `data_valid` stays 0 and `data_out` is unchanged. A follow-on frame 0x01 (parity 1) → `data_out`=0x01.
- **Frame error:** frame 0x55 with a correct parity bit 0 and stop bit 1, then `serial_in`=0 → `frame_error` pulses for 1 cycle with no `data_valid`. The next edge does not start a frame.
- **Overrun and handshake:** frames 0x81 then 0x7E back-to-back with `data_ready`=0 → `data_out`=0x81 held and `overrun` pulses at the end of the second frame. Raising `data_ready` for 1 cycle → `data_valid` falls. Repeat with `data_ready`=1 exactly on the second stop edge → `data_out`=0x7E, `data_valid` stays 1, no `overrun`.
- **Clear mid-frame:** assert `clear` for 1 cycle after 4 data bits of 0xF0 → no flags and no valid. A subsequent full frame 0x0F (parity 0) → `data_out`=0x0F.
